// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: widths, local opcodes,
// the instruction word layout and the FSM state encoding.
package instr_fetch_sequencer_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned OPC_W  = 4;
   localparam int unsigned WAIT_W = 2;

   localparam logic [OPC_W-1:0] OPC_JMP  = 4'hE;
   localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

   // RAM word layout: high nibble is the address operand, low nibble the opcode
   typedef struct packed {
      logic [OPC_W-1:0] endereco;
      logic [OPC_W-1:0] opcode;
   } instr_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DECODE = 3'd3,
      ST_ISSUE  = 3'd4,
      ST_PAUSE  = 3'd5,
      ST_HALTED = 3'd6
   } state_t;

   // busy covers every state that belongs to a running program
   function automatic logic state_is_busy(input state_t s);
      return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_DECODE) ||
             (s == ST_ISSUE) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the program RAM read port and the ULA.
//  mem_rd_en/mem_addr/mem_rdata : RAM read port (sequencer is master)
//  ins_valid/ins_ready          : instruction handshake towards the ULA
//  opcode/endereco              : instruction payload towards the ULA
interface instr_fetch_sequencer_if;
   import instr_fetch_sequencer_pkg::*;

   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              ins_valid;
   logic              ins_ready;
   logic [OPC_W-1:0]  opcode;
   logic [OPC_W-1:0]  endereco;

   modport master (
      output mem_rd_en, mem_addr, ins_valid, opcode, endereco,
      input  mem_rdata, ins_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, ins_valid, opcode, endereco,
      output mem_rdata, ins_ready
   );

endinterface

// File: rtl/instr_fetch_sequencer_rise_edge_detect.sv
// Rising-edge detector: turns a level input into a one-cycle pulse.
//  i_clock   : rising-edge clock
//  i_reset   : synchronous active-high reset
//  i_d       : level input
//  o_pulse_c : high for the cycle in which i_d is 1 and was 0 on the previous edge
module instr_fetch_sequencer_rise_edge_detect (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_pulse_c
);

   logic r_prev;

   always_ff @(posedge i_clock) begin
      if (i_reset) r_prev <= 1'b0;
      else         r_prev <= i_d;
   end

   assign o_pulse_c = i_d & ~r_prev;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Sequential instruction fetcher for the 16x8 program RAM. Fetches a word, waits
// MEM_LAT cycles, decodes HALT/JMP locally and hands every other instruction to
// the ULA over valid/ready. Supports free-run and single-step operation.
//  i_clock     : rising-edge clock
//  i_reset     : synchronous active-high reset
//  i_start     : level, accepted in IDLE/HALTED, restarts at pc 0
//  i_step_mode : pause after each issued instruction
//  i_step      : level, rising edge releases PAUSE
//  fetch_bus   : RAM read port + ULA handshake (master side)
//  o_pc        : program counter
//  o_busy      : program running (FETCH..PAUSE)
//  o_halted    : HALT executed
module instr_fetch_sequencer
   import instr_fetch_sequencer_pkg::*;
#(
   parameter int unsigned      MEM_LAT = 1,
   parameter logic [OPC_W-1:0] OP_JMP  = OPC_JMP,
   parameter logic [OPC_W-1:0] OP_HALT = OPC_HALT
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic                      i_step_mode,
   input  logic                      i_step,
   instr_fetch_sequencer_if.master   fetch_bus,
   output logic [ADDR_W-1:0]         o_pc,
   output logic                      o_busy,
   output logic                      o_halted
);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_next_pc;
   instr_t            r_instr;
   instr_t            w_next_instr;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_next_wait_cnt;
   logic              r_mem_rd_en;
   logic              r_ins_valid;
   logic              r_busy;
   logic              r_halted;
   logic              w_step_pulse;

   instr_fetch_sequencer_rise_edge_detect u_step_edge (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_d       (i_step),
      .o_pulse_c (w_step_pulse)
   );

   // state register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // next-state, pc, instruction register and wait counter
   always_comb begin
      w_next_state    = r_state;
      w_next_pc       = r_pc;
      w_next_instr    = r_instr;
      w_next_wait_cnt = r_wait_cnt;
      case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (i_start) begin
               w_next_state = ST_FETCH;
               w_next_pc    = '0;
            end
         end
         ST_FETCH: begin
            w_next_state    = ST_WAIT;
            w_next_wait_cnt = '0;
         end
         ST_WAIT: begin
            // read data is valid in the last wait cycle
            if (r_wait_cnt == WAIT_W'(MEM_LAT - 1)) begin
               w_next_instr = instr_t'(fetch_bus.mem_rdata);
               w_next_state = ST_DECODE;
            end else begin
               w_next_wait_cnt = r_wait_cnt + WAIT_W'(1);
            end
         end
         ST_DECODE: begin
            if (r_instr.opcode == OP_HALT) begin
               w_next_state = ST_HALTED;
            end else if (r_instr.opcode == OP_JMP) begin
               w_next_pc    = ADDR_W'(r_instr.endereco);
               w_next_state = ST_FETCH;
            end else begin
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (fetch_bus.ins_ready) begin
               w_next_pc    = r_pc + ADDR_W'(1);
               w_next_state = i_step_mode ? ST_PAUSE : ST_FETCH;
            end
         end
         ST_PAUSE: begin
            if (w_step_pulse) w_next_state = ST_FETCH;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // datapath and registered status outputs, decoded from the upcoming state
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pc        <= '0;
         r_instr     <= '0;
         r_wait_cnt  <= '0;
         r_mem_rd_en <= 1'b0;
         r_ins_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_pc        <= w_next_pc;
         r_instr     <= w_next_instr;
         r_wait_cnt  <= w_next_wait_cnt;
         r_mem_rd_en <= (w_next_state == ST_FETCH);
         r_ins_valid <= (w_next_state == ST_ISSUE);
         r_busy      <= state_is_busy(w_next_state);
         r_halted    <= (w_next_state == ST_HALTED);
      end
   end

   assign fetch_bus.mem_rd_en = r_mem_rd_en;
   assign fetch_bus.mem_addr  = r_pc;
   assign fetch_bus.ins_valid = r_ins_valid;
   assign fetch_bus.opcode    = r_instr.opcode;
   assign fetch_bus.endereco  = r_instr.endereco;
   assign o_pc                = r_pc;
   assign o_busy              = r_busy;
   assign o_halted            = r_halted;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: program table, hand-written
// corner sequences and random programs against an instruction-level interpreter.
module tb_instr_fetch_sequencer;
   import instr_fetch_sequencer_pkg::*;

   localparam int unsigned MEM_LAT = 1;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] e;
      logic [3:0] pc;
   } iss_t;

   typedef struct packed {
      logic [127:0] prog;
      logic [7:0]   n_iss;
      logic [3:0]   exp_pc;
      logic [7:0]   first;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              step_mode;
   logic              step;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic              rnd_ready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] ram [16];
   logic [7:0] mem_pipe [MEM_LAT];
   logic [3:0] rd_log [$];
   iss_t       iss_log [$];
   int         hs_cycle [$];

   // reference interpreter results
   iss_t       m_iss [$];
   int         m_fidx [$];
   logic [3:0] m_reads [$];
   logic       m_halted;
   logic [3:0] m_pc;

   vec_t vecs [5];

   always #5 clk = ~clk;

   instr_fetch_sequencer_if bus ();

   instr_fetch_sequencer #(.MEM_LAT(MEM_LAT)) dut (
      .i_clock     (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_step_mode (step_mode),
      .i_step      (step),
      .fetch_bus   (bus.master),
      .o_pc        (pc),
      .o_busy      (busy),
      .o_halted    (halted)
   );

   // RAM read port with MEM_LAT cycles of latency
   always @(posedge clk) begin
      mem_pipe[0] <= ram[bus.mem_addr];
      for (int k = 1; k < MEM_LAT; k++) mem_pipe[k] <= mem_pipe[k-1];
   end
   assign bus.mem_rdata = mem_pipe[MEM_LAT-1];

   // bus monitor: fetch addresses and completed handshakes
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         if (bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
         if (bus.ins_valid && bus.ins_ready) begin
            iss_log.push_back('{bus.opcode, bus.endereco, pc});
            hs_cycle.push_back(cyc);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      if (rnd_ready) bus.ins_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      iss_log.delete();
      hs_cycle.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic fill_ram(input logic [7:0] w);
      for (int a = 0; a < 16; a++) ram[a] = w;
   endtask

   // executes the stored program instruction by instruction
   task automatic run_model(input int max_fetch);
      logic [3:0] mpc;
      logic [7:0] w;
      logic       h;
      m_iss.delete();
      m_fidx.delete();
      m_reads.delete();
      mpc = 4'd0;
      h   = 1'b0;
      for (int f = 0; f < max_fetch && !h; f++) begin
         w = ram[mpc];
         m_reads.push_back(mpc);
         if (w[3:0] == 4'hF) begin
            h = 1'b1;
         end else if (w[3:0] == 4'hE) begin
            mpc = w[7:4];
         end else begin
            m_iss.push_back('{w[3:0], w[7:4], mpc});
            m_fidx.push_back(f);
            mpc = mpc + 4'd1;
         end
      end
      m_pc     = mpc;
      m_halted = h;
   endtask

   task automatic wait_halt(input string name, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         tick();
         n++;
      end
      check({name, "_halt_in_time"}, 32'(halted), 32'd1);
   endtask

   task automatic wait_issues(input string name, input int cnt, input int budget);
      int n = 0;
      while (iss_log.size() < cnt && n < budget) begin
         tick();
         n++;
      end
      check({name, "_issue_in_time"}, 32'(iss_log.size() >= cnt), 32'd1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!bus.ins_valid && n < budget) begin
         tick();
         n++;
      end
      check({name, "_valid_in_time"}, 32'(bus.ins_valid), 32'd1);
   endtask

   task automatic wait_rd_en(input string name, input int budget);
      int n = 0;
      while (!bus.mem_rd_en && n < budget) begin
         tick();
         n++;
      end
      check({name, "_rd_en_in_time"}, 32'(bus.mem_rd_en), 32'd1);
   endtask

   initial begin
      logic [127:0] p;
      int lat;
      reset         = 1'b1;
      start         = 1'b0;
      step_mode     = 1'b0;
      step          = 1'b0;
      rnd_ready     = 1'b0;
      bus.ins_ready = 1'b0;
      fill_ram(8'h00);
      for (int k = 0; k < int'(MEM_LAT); k++) mem_pipe[k] = 8'h00;

      vecs[0] = '{{104'h0, 8'h0F, 8'h52, 8'h31},        8'd2,  4'd2,  8'h31};
      vecs[1] = '{{96'h0, 8'h0F, 8'h77, 8'h3E, 8'h41},  8'd1,  4'd3,  8'h41};
      vecs[2] = '{{120'h0, 8'h0F},                      8'd0,  4'd0,  8'h00};
      vecs[3] = '{{96'h0, 8'h0F, 8'h07, 8'h99, 8'h2E},  8'd1,  4'd3,  8'h07};
      vecs[4] = '{{8'h0F, {15{8'h93}}},                 8'd15, 4'd15, 8'h93};

      // reset state
      tick();
      tick();
      do_reset();
      check("reset_outputs",
            {27'd0, bus.ins_valid, bus.mem_rd_en, busy, halted, 1'b0},
            32'd0);
      check("reset_pc", 32'(pc), 32'd0);
      check("reset_instr", {24'd0, bus.endereco, bus.opcode}, 32'd0);

      // program table, free-run, ULA always ready
      for (int i = 0; i < 5; i++) begin
         do_reset();
         p = vecs[i].prog;
         for (int a = 0; a < 16; a++) ram[a] = p[8*a +: 8];
         run_model(64);
         bus.ins_ready = 1'b1;
         pulse_start();
         wait_halt($sformatf("vec%0d", i), 300);
         check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
         check($sformatf("vec%0d_n_issue", i), 32'(iss_log.size()), 32'(vecs[i].n_iss));
         if (vecs[i].n_iss != 8'd0)
            check($sformatf("vec%0d_first", i), {24'd0, iss_log[0].e, iss_log[0].op},
                  32'(vecs[i].first));
         check($sformatf("vec%0d_n_reads", i), 32'(rd_log.size()), 32'(m_reads.size()));
         for (int j = 0; j < m_reads.size(); j++)
            check($sformatf("vec%0d_read%0d", i, j), 32'(rd_log[j]), 32'(m_reads[j]));
         for (int j = 0; j < m_iss.size(); j++)
            check($sformatf("vec%0d_issue%0d", i, j), 32'(iss_log[j]), 32'(m_iss[j]));
      end

      // restart from HALTED begins again at pc 0
      pulse_start();
      check("restart_pc", 32'(pc), 32'd0);
      check("restart_busy", {30'd0, busy, halted}, 32'd2);

      // start-to-valid latency and free-run throughput
      do_reset();
      p = vecs[0].prog;
      for (int a = 0; a < 16; a++) ram[a] = p[8*a +: 8];
      bus.ins_ready = 1'b1;
      pulse_start();
      lat = 0;
      while (!bus.ins_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency_edges_after_start", 32'(lat), 32'd3);
      wait_halt("thru", 100);
      check("thru_interval", 32'(hs_cycle[1] - hs_cycle[0]), 32'd4);

      // ULA stall: payload and pc held for 10 cycles
      do_reset();
      fill_ram(8'h21);
      bus.ins_ready = 1'b0;
      pulse_start();
      wait_valid("stall", 20);
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("stall_hold%0d", c),
               {19'd0, bus.ins_valid, bus.opcode, bus.endereco, pc},
               {19'd0, 1'b1, 4'h1, 4'h2, 4'h0});
      end
      check("stall_no_issue", 32'(iss_log.size()), 32'd0);
      bus.ins_ready = 1'b1;
      tick();
      check("stall_release_issue", 32'(iss_log.size()), 32'd1);
      check("stall_release_pc", 32'(pc), 32'd1);

      // single-step
      do_reset();
      fill_ram(8'h21);
      step_mode     = 1'b1;
      bus.ins_ready = 1'b1;
      pulse_start();
      wait_issues("step_first", 1, 20);
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("step_pause_busy%0d", c), 32'(busy), 32'd1);
      end
      step_mode = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      check("step_mode_clear_holds", 32'(iss_log.size()), 32'd1);
      check("step_mode_clear_busy", 32'(busy), 32'd1);
      step_mode = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step = 1'b1;
         for (int c = 0; c < 3; c++) tick();
         step = 1'b0;
         for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("step%0d_busy%0d", s, c), 32'(busy), 32'd1);
         end
         check($sformatf("step%0d_count", s), 32'(iss_log.size()), 32'(2 + s));
      end
      // a step edge while stalled in ISSUE must not pre-release the next pause
      bus.ins_ready = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_valid("step_discard", 20);
      step = 1'b1;
      tick();
      tick();
      step = 1'b0;
      tick();
      bus.ins_ready = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      check("step_discard_count", 32'(iss_log.size()), 32'd5);
      check("step_discard_busy", 32'(busy), 32'd1);
      step_mode = 1'b0;

      // pc wrap without HALT
      do_reset();
      fill_ram(8'h01);
      bus.ins_ready = 1'b1;
      pulse_start();
      begin
         int n = 0;
         while (rd_log.size() < 17 && n < 200) begin
            tick();
            n++;
         end
      end
      check("wrap_reads", 32'(rd_log.size()), 32'd17);
      check("wrap_read15", 32'(rd_log[15]), 32'd15);
      check("wrap_read16", 32'(rd_log[16]), 32'd0);
      check("wrap_issue15_pc", 32'(iss_log[15].pc), 32'd15);
      check("wrap_pc", 32'(pc), 32'd0);

      // reset during WAIT
      wait_issues("rst_wait", 19, 40);
      wait_rd_en("rst_wait", 10);
      tick();
      reset = 1'b1;
      tick();
      check("rst_wait_outputs",
            {27'd0, bus.ins_valid, bus.mem_rd_en, busy, halted, 1'b0}, 32'd0);
      check("rst_wait_pc", 32'(pc), 32'd0);
      reset = 1'b0;
      tick();
      check("rst_wait_idle", 32'(busy), 32'd0);

      // reset during ISSUE
      clear_logs();
      pulse_start();
      wait_issues("rst_issue", 2, 40);
      bus.ins_ready = 1'b0;
      wait_valid("rst_issue", 20);
      check("rst_issue_pc_before", 32'(pc), 32'd2);
      reset = 1'b1;
      tick();
      check("rst_issue_valid", 32'(bus.ins_valid), 32'd0);
      check("rst_issue_pc", 32'(pc), 32'd0);
      check("rst_issue_instr", {24'd0, bus.endereco, bus.opcode}, 32'd0);
      reset = 1'b0;
      tick();

      // random programs with a randomly stalling ULA
      for (int r = 0; r < 20; r++) begin
         int  n;
         bit  exp_halt;
         int  nexp;
         rnd_ready = 1'b0;
         do_reset();
         for (int a = 0; a < 16; a++) ram[a] = 8'($urandom);
         run_model(200);
         exp_halt  = (m_reads.size() <= 24);
         rnd_ready = 1'b1;
         pulse_start();
         n = 0;
         while (!(exp_halt ? halted : (rd_log.size() >= 24)) && n < 2000) begin
            tick();
            n++;
         end
         check($sformatf("rand%0d_done", r), 32'(n < 2000), 32'd1);
         check($sformatf("rand%0d_halted", r), 32'(halted), 32'(exp_halt));
         if (exp_halt) begin
            check($sformatf("rand%0d_pc", r), 32'(pc), 32'(m_pc));
            nexp = m_iss.size();
         end else begin
            nexp = 0;
            for (int j = 0; j < m_iss.size(); j++)
               if (m_fidx[j] <= 22) nexp = j + 1;
         end
         check($sformatf("rand%0d_n_issue", r), 32'(iss_log.size()), 32'(nexp));
         for (int j = 0; j < nexp; j++)
            check($sformatf("rand%0d_issue%0d", r, j), 32'(iss_log[j]), 32'(m_iss[j]));
         for (int j = 0; j < rd_log.size() && j < m_reads.size(); j++)
            check($sformatf("rand%0d_read%0d", r, j), 32'(rd_log[j]), 32'(m_reads[j]));
      end
      rnd_ready = 1'b0;
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
